fir_filter_serial: RTL
======================

# fir_filter_serial

Time-multiplexed, single-multiplier FIR filter with the same sample stream semantics and coefficient set as the parallel transposed FIR. Each accepted input sample is written into a circular history buffer, then one MAC per cycle walks the buffer newest-to-oldest to produce one output sample. It sits in the same datapath slot as the parallel filter when the sample rate is at least FIR_DEPTH+2 clocks per sample, trading throughput for a single multiplier.

## Interface
- DATA_WIDTH, 24, signed sample and coefficient width (Q1.(DATA_WIDTH-1))
- FIR_DEPTH, 16, number of taps; power of two, at least 2
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  global enable; when low, all state, including the FSM, buffer, accumulator and outputs, holds
- iv_din  in  DATA_WIDTH  signed input sample
- i_din_valid  in  1  input sample valid
- o_din_ready  out  1  block can accept a sample this cycle
- ov_dout  out  DATA_WIDTH  signed filtered sample, held between results
- o_dout_valid  out  1  one-cycle pulse marking a new ov_dout

## Operation
- Reset values:
  - o_din_ready=0 during reset, 1 in the first IDLE cycle after reset
  - ov_dout=0, o_dout_valid=0
  - all history entries=0, write pointer=0, accumulator=0, FSM=IDLE
- Accept condition: i_en & i_din_valid & o_din_ready. o_din_ready is 1 only in IDLE.
- IDLE, on accept:
  - write iv_din at wr_ptr
  - latch rd_ptr=wr_ptr, tap index=0
  - clear the accumulator
  - increment wr_ptr modulo FIR_DEPTH, with natural wrap
  - go to MAC
- MAC, one cycle per tap:
  - acc += hist[rd_ptr] * FIR_WEIGHTS[tap]
  - rd_ptr decrements modulo FIR_DEPTH, wrapping 0 to FIR_DEPTH-1
  - tap increments
  - after tap FIR_DEPTH-1 is accumulated, go to OUT
- OUT:
  - register the scaled result into ov_dout
  - pulse o_dout_valid
  - return to IDLE
- Tap 0 uses the newest sample and tap FIR_DEPTH-1 the oldest. The output equals sum over k of w[k]*x[n-k], the same response as the parallel filter.
- Arithmetic:
  - each product is full 2*DATA_WIDTH signed
  - the accumulator is 2*DATA_WIDTH+clog2(FIR_DEPTH) bits, so it never overflows
  - result = acc >>> (DATA_WIDTH-1), arithmetic shift, truncation toward minus infinity
  - the result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
- i_din_valid asserted outside IDLE is ignored because ready is 0. The source must hold the sample until the handshake completes.
- i_en low mid-MAC freezes the computation. It resumes exactly where it stopped when i_en returns high, with no lost or repeated taps.
- i_rst mid-operation returns immediately to the reset state. The in-flight result is discarded, o_dout_valid is never asserted for it, and history is cleared.

## Timing
- With i_en held high, accept on edge E gives:
  - MAC on edges E+1..E+FIR_DEPTH
  - ov_dout updated and o_dout_valid high after edge E+FIR_DEPTH+1, for exactly one cycle
- o_din_ready rises after edge E+FIR_DEPTH+1, in the same cycle as o_dout_valid. The next accept is possible on edge E+FIR_DEPTH+2.
- Maximum throughput is one sample per FIR_DEPTH+2 clocks.
- Everything is registered: o_din_ready decodes the FSM state register, and there is no combinational path from inputs to outputs.

## Structure
- Shared package fir_pkg holds:
  - FIR_WEIGHTS, the coefficient array, shared with the parallel filter so both produce identical responses
  - the accumulator width function
  - the FSM state encoding (IDLE, MAC, OUT)
- One sub-module: fir_mac_unit, a signed multiply-accumulate with clear, enable and saturating scale-out. The top level owns the FSM, pointers and history buffer.

## Test plan
- Reset check: assert i_rst asynchronously mid-cycle. All outputs read 0 immediately, and o_din_ready=1 in the first idle cycle after release.
- Impulse: feed 0x400000 (0.5) then FIR_DEPTH-1 zeros, each on the first ready cycle. Output k = FIR_WEIGHTS[k]>>>1, produced FIR_DEPTH+1 edges after each accept.
- DC saturation: feed 0x7FFFFF for 2*FIR_DEPTH samples. Steady-state output = sat(sum(FIR_WEIGHTS)*0x7FFFFF>>>23); feeding 0x800000 gives the negative saturation value.
- Wrap-around: feed 3*FIR_DEPTH random samples. Every output matches a reference model of the parallel filter, including outputs computed across the wr_ptr wrap.
- Enable stall: drop i_en for 5 cycles during MAC tap 7. The result is identical to an unstalled run, and o_dout_valid is delayed by exactly 5 cycles.
- Backpressure and reset abort:
  - hold i_din_valid high continuously: accepts occur only every FIR_DEPTH+2 cycles, and no sample is double-accepted
  - assert i_rst during MAC: no o_dout_valid pulse for the aborted sample

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filters: coefficient set, accumulator sizing
// and the serial filter's FSM encoding.
package fir_pkg;

    localparam int FIR_COEF_W   = 24;
    localparam int FIR_MAX_TAPS = 16;

    // Q1.23 coefficients; tap 0 multiplies the newest sample. The DC gain is
    // deliberately above 1.0 so full-scale DC input exercises saturation.
    localparam logic signed [FIR_COEF_W-1:0] FIR_WEIGHTS [FIR_MAX_TAPS] = '{
        24'sh010000, 24'sh020000, 24'sh040000, 24'sh080000,
        24'sh100000, 24'sh180000, 24'sh200000, 24'sh280000,
        24'sh280000, 24'sh200000, 24'sh180000, 24'sh100000,
        24'sh080000, 24'sh040000, 24'sh020000, -24'sh010000
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    // Full-precision products plus enough guard bits that summing every tap
    // can never overflow.
    function automatic int fir_acc_width(input int data_width, input int depth);
        return 2 * data_width + $clog2(depth);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and a saturating
// Q1.(DATA_WIDTH-1) scale-out of the accumulator.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clr,
    input  logic                         i_acc_en,
    input  logic signed [DATA_WIDTH-1:0] iv_a,
    input  logic signed [DATA_WIDTH-1:0] iv_b,
    output logic signed [DATA_WIDTH-1:0] ov_result
);

    localparam int ACC_WIDTH = fir_acc_width(DATA_WIDTH, FIR_DEPTH);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_shifted;

    assign w_prod = iv_a * iv_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + ACC_WIDTH'(w_prod);
        end
    end

    // Arithmetic shift truncates toward minus infinity before clamping.
    assign w_shifted = r_acc >>> (DATA_WIDTH - 1);

    always_comb begin
        ov_result = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            ov_result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            ov_result = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_filter_serial.sv
// Single-multiplier FIR: samples land in a circular history buffer and one
// MAC per cycle walks it newest-to-oldest to build each output.
module fir_filter_serial
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] iv_din,
    input  logic                         i_din_valid,
    output logic                         o_din_ready,
    output logic signed [DATA_WIDTH-1:0] ov_dout,
    output logic                         o_dout_valid
);

    localparam int              PTR_W    = $clog2(FIR_DEPTH);
    localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(FIR_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    fir_state_t r_state;
    fir_state_t w_next_state;

    logic                         r_ready;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [PTR_W-1:0]             r_tap;
    logic signed [DATA_WIDTH-1:0] r_hist [FIR_DEPTH];

    logic                         w_accept;
    logic                         w_acc_en;
    logic signed [DATA_WIDTH-1:0] w_sample;
    logic signed [DATA_WIDTH-1:0] w_coef;
    logic signed [DATA_WIDTH-1:0] w_result;

    // Handshake: a sample transfers on a rising edge where i_en, i_din_valid
    // and o_din_ready are all high; o_din_ready is a register that is high
    // only while the FSM sits in IDLE, so it never depends on inputs.
    assign o_din_ready = r_ready;
    assign w_accept    = i_en & i_din_valid & r_ready;
    assign w_acc_en    = i_en & (r_state == ST_MAC);
    assign w_sample    = r_hist[r_rd_ptr];
    assign w_coef      = DATA_WIDTH'(FIR_WEIGHTS[r_tap]);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_MAC;
            ST_MAC:  if (r_tap == LAST_TAP) w_next_state = ST_OUT;
            ST_OUT:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Every register holds while i_en is low, so a stall resumes on the same tap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tap        <= '0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
            for (int i = 0; i < FIR_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (i_en) begin
            r_state      <= w_next_state;
            r_ready      <= (w_next_state == ST_IDLE);
            o_dout_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hist[r_wr_ptr] <= iv_din;
                        r_rd_ptr         <= r_wr_ptr;
                        r_tap            <= '0;
                        r_wr_ptr         <= r_wr_ptr + PTR_ONE;
                    end
                end
                ST_MAC: begin
                    r_rd_ptr <= r_rd_ptr - PTR_ONE;
                    r_tap    <= r_tap + PTR_ONE;
                end
                ST_OUT: begin
                    ov_dout      <= w_result;
                    o_dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    fir_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIR_DEPTH  (FIR_DEPTH)
    ) u_mac (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_accept),
        .i_acc_en  (w_acc_en),
        .iv_a      (w_sample),
        .iv_b      (w_coef),
        .ov_result (w_result)
    );

endmodule
